i2s_rx_sample: RTL and testbench

- Slave-mode I2S receiver; sits directly upstream of effects_pipeline.
- Oversamples codec BCLK/LRCLK/SDATA on the system clock and deserialises one 16-bit signed PCM sample per frame.
- Presents each sample with a one-cycle valid strobe that drives effects_pipeline sample_in/valid.
- Selects left, right or mono (averaged) channel; flags malformed slots.

---
 rtl/i2s_rx_sample.sv | 144 ++++++++++++++
 tb/tb_i2s_rx_sample.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sample.sv
// Slave-mode I2S receiver: oversamples BCLK/LRCLK/SDATA on clk, deserialises one
// SLEN-bit signed sample per frame and emits left, right or the mono average.
module i2s_rx_sample #(
  parameter int SLEN     = 16,
  parameter int CHANNEL  = 0,
  parameter int MAX_SLOT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i2s_bclk,
  input  logic            i2s_lrclk,
  input  logic            i2s_sdata,
  output logic [SLEN-1:0] sample_out,
  output logic            sample_valid,
  output logic            frame_err
);
  localparam int CW = $clog2(MAX_SLOT + 1);
  localparam logic [CW-1:0] SLEN_C = CW'(SLEN);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_SLOT);

  typedef enum logic [1:0] {UNLOCKED, DELAY, SHIFT, HOLD} state_t;
  state_t state, state_nxt;

  logic [2:0]      bclk_s;   // [0] sync1, [1] sync2, [2] history
  logic [1:0]      lr_s, sd_s;
  logic            lr_last, lr_known;
  logic            slot, slot_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [SLEN-1:0] sreg, sreg_nxt, word, left_q, right_q, out_nxt;
  logic [SLEN:0]   mono_sum;
  logic            left_ok;
  logic            rise, lr_edge, latch, err, emit;
  logic [1:0]      vld_pipe;

  assign rise    = bclk_s[1] & ~bclk_s[2];
  // lr_known stops the reset value of lr_last from faking an edge
  assign lr_edge = rise & lr_known & (lr_s[1] != lr_last);
  assign word    = {sreg[SLEN-2:0], sd_s[1]};
  assign cnt_inc = (cnt == MAX_C) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  // The rise that carries an LRCLK change also carries the previous slot's last
  // bit, so the shift for the old slot happens before the slot is closed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    slot_nxt  = slot;
    latch     = 1'b0;
    err       = 1'b0;
    if (rise) begin
      unique case (state)
        UNLOCKED: ;
        DELAY: begin
          sreg_nxt  = word;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: begin
          sreg_nxt = word;
          cnt_nxt  = cnt_inc;
          if (cnt_inc == SLEN_C) begin
            latch     = 1'b1;
            state_nxt = HOLD;
          end else if (lr_edge) begin
            err = 1'b1;
          end
        end
        HOLD: cnt_nxt = cnt_inc;
        default: ;
      endcase
      if (lr_edge) begin
        state_nxt = DELAY;
        cnt_nxt   = '0;
        slot_nxt  = lr_s[1];
      end
    end
  end

  always_comb begin
    emit = 1'b0;
    if (CHANNEL == 0)      emit = latch & ~slot;
    else if (CHANNEL == 1) emit = latch & slot;
    else                   emit = latch & slot & left_ok;
  end

  assign mono_sum = {left_q[SLEN-1], left_q} + {right_q[SLEN-1], right_q};

  always_comb begin
    out_nxt = right_q;
    if (CHANNEL == 0)      out_nxt = left_q;
    else if (CHANNEL == 2) out_nxt = mono_sum[SLEN:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s     <= '0;
      lr_s       <= '0;
      sd_s       <= '0;
      lr_last    <= 1'b0;
      lr_known   <= 1'b0;
      slot       <= 1'b0;
      cnt        <= '0;
      sreg       <= '0;
      left_q     <= '0;
      right_q    <= '0;
      left_ok    <= 1'b0;
      vld_pipe   <= '0;
      sample_out <= '0;
      frame_err  <= 1'b0;
    end else begin
      bclk_s    <= {bclk_s[1:0], i2s_bclk};
      lr_s      <= {lr_s[0], i2s_lrclk};
      sd_s      <= {sd_s[0], i2s_sdata};
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
      slot      <= slot_nxt;
      frame_err <= err;
      if (rise) begin
        lr_last  <= lr_s[1];
        lr_known <= 1'b1;
      end
      // a new left slot invalidates the pairing until its word completes
      if (lr_edge & ~lr_s[1]) left_ok <= 1'b0;
      if (latch & ~slot) begin
        left_q  <= word;
        left_ok <= 1'b1;
      end
      if (latch & slot) begin
        right_q <= word;
        left_ok <= 1'b0;
      end
      vld_pipe <= {vld_pipe[0], emit};
      if (vld_pipe[0]) sample_out <= out_nxt;
    end
  end

  assign sample_valid = vld_pipe[1];

endmodule

// File: tb/tb_i2s_rx_sample.sv
// Bench for i2s_rx_sample: three instances (left, right, mono) fed one I2S stream,
// checked against a slot-level reference model for values, latency and errors.
module tb_i2s_rx_sample;
  localparam int SLEN = 16;

  logic clk = 1'b0, rst = 1'b0, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic [SLEN-1:0] so [3];
  logic sv [3];
  logic fe [3];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    i2s_rx_sample #(.SLEN(SLEN), .CHANNEL(g), .MAX_SLOT(32)) dut (
      .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
      .sample_out(so[g]), .sample_valid(sv[g]), .frame_err(fe[g]));
  end

  // stream description: slot k has channel s_ch, width s_w, word s_val (MSB first)
  int s_ch[$], s_w[$];
  longint s_val[$];
  bit p_lr[$], p_sd[$];
  int rise_cyc[$];
  int exp_v [3][$], exp_p [3][$], exp_err;
  int act_v [3][$], act_c [3][$], fe_cnt [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (sv[d]) begin
        act_v[d].push_back(int'(so[d]));
        act_c[d].push_back(cyc);
      end
      if (fe[d]) fe_cnt[d]++;
    end
  end

  function automatic int sx(int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int pick_w();
    int r = $urandom_range(0, 9);
    if (r < 2) return $urandom_range(2, 12);
    if (r < 5) return 16;
    if (r < 7) return 24;
    return 32;
  endfunction

  task automatic add_slot(int w, longint v);
    s_ch.push_back((s_ch.size() % 2 == 0) ? 1 : 0);
    s_w.push_back(w);
    s_val.push_back(v & ((64'd1 << w) - 1));
  endtask

  task automatic new_stream();
    s_ch.delete(); s_w.delete(); s_val.delete();
    add_slot(4, 0);  // right-slot preamble so the first left slot starts on an edge
  endtask

  // I2S timing: data lags LRCLK by one bit; a final period on the opposite
  // channel delivers the last slot's LSB together with a closing edge.
  task automatic build();
    bit d[$];
    p_lr.delete(); p_sd.delete(); rise_cyc.delete();
    for (int k = 0; k < s_w.size(); k++)
      for (int i = 0; i < s_w[k]; i++) begin
        p_lr.push_back(s_ch[k] != 0);
        d.push_back(((s_val[k] >> (s_w[k] - 1 - i)) & 1) != 0);
      end
    p_lr.push_back(!p_lr[p_lr.size() - 1]);
    p_sd.push_back(1'b0);
    for (int i = 0; i < d.size(); i++) p_sd.push_back(d[i]);
    for (int i = 0; i < p_lr.size(); i++) rise_cyc.push_back(0);
  endtask

  task automatic play(int from, int to);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      bclk = 1'b0; lrclk = p_lr[k]; sdata = p_sd[k];
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      rise_cyc[k] = cyc;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  // Expected outputs from slot k >= first: a slot of at least SLEN bits yields its
  // top SLEN bits, known SLEN bit-periods after the slot's first period; shorter
  // slots are errors. Mono pairs a right word with a good left word of its frame.
  task automatic model(int first);
    int st = 0, lv = 0, top, per;
    bit l_ok = 0;
    exp_err = 0;
    for (int d = 0; d < 3; d++) begin exp_v[d].delete(); exp_p[d].delete(); end
    for (int k = 0; k < s_w.size(); k++) begin
      if (k >= first) begin
        if (s_ch[k] == 0) l_ok = 0;
        if (s_w[k] < SLEN) exp_err++;
        else begin
          top = int'(s_val[k] >> (s_w[k] - SLEN)) & 'hFFFF;
          per = st + SLEN;
          if (s_ch[k] == 0) begin
            exp_v[0].push_back(top); exp_p[0].push_back(per);
            l_ok = 1; lv = top;
          end else begin
            exp_v[1].push_back(top); exp_p[1].push_back(per);
            if (l_ok) begin
              exp_v[2].push_back(((sx(lv) + sx(top)) >>> 1) & 'hFFFF);
              exp_p[2].push_back(per);
            end
            l_ok = 0;
          end
        end
      end
      st += s_w[k];
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 3; d++) begin
      act_v[d].delete(); act_c[d].delete(); fe_cnt[d] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bclk = 1'b1; lrclk = 1'b1; sdata = 1'b1;
    repeat (5) @(negedge clk);
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (so[d] !== '0 || sv[d] !== 1'b0 || fe[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: out=%h valid=%b err=%b, required 0/0/0", d, so[d], sv[d], fe[d]);
      end
    end
    // BCLK running with LRCLK held: receiver must stay unlocked
    clear_mon();
    new_stream();
    s_w[0] = 40;
    build();
    play(0, p_lr.size());
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== 0 || fe_cnt[d] !== 0) begin
        n_fail++;
        $display("FAIL unlocked[%0d]: %0d samples %0d errs, required 0/0", d, act_v[d].size(), fe_cnt[d]);
      end
    end
  endtask

  task automatic test_channels();
    int k0 [4] = '{'h1234, 'h1000, 'h8000, 'h7FFF};
    int k1 [4] = '{'hABCD, 'h3000, 'h8000, 'h0001};
    int k2 [4] = '{'hDF00, 'h2000, 'h8000, 'h4000};
    do_reset(); clear_mon(); new_stream();
    for (int i = 0; i < 4; i++) begin add_slot(16, k0[i]); add_slot(16, k1[i]); end
    build(); play(0, p_lr.size()); model(1);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== exp_v[d].size() || fe_cnt[d] !== exp_err) begin
        n_fail++;
        $display("FAIL chan_count[%0d]: %0d samples %0d errs, required %0d/%0d", d, act_v[d].size(), fe_cnt[d], exp_v[d].size(), exp_err);
      end else for (int i = 0; i < exp_v[d].size(); i++) begin
        n_chk++;
        if (act_v[d][i] !== exp_v[d][i] || act_c[d][i] - rise_cyc[exp_p[d][i]] !== 4) begin
          n_fail++;
          $display("FAIL chan_sample[%0d][%0d]: %h after %0d clk, required %h after 4", d, i, act_v[d][i], act_c[d][i] - rise_cyc[exp_p[d][i]], exp_v[d][i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_v[0].size() != 4 || act_v[1].size() != 4 || act_v[2].size() != 4 ||
          act_v[0][i] !== k0[i] || act_v[1][i] !== k1[i] || act_v[2][i] !== k2[i]) begin
        n_fail++;
        $display("FAIL chan_const[%0d]: L/R/M not %h/%h/%h", i, k0[i], k1[i], k2[i]);
      end
    end
  endtask

  task automatic test_slot32();
    do_reset(); clear_mon(); new_stream();
    add_slot(32, 64'hCAFE_5A5A); add_slot(32, longint'($urandom));
    add_slot(32, longint'($urandom)); add_slot(32, longint'($urandom));
    build(); play(0, p_lr.size()); model(1);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== exp_v[d].size() || fe_cnt[d] !== 0) begin
        n_fail++;
        $display("FAIL s32_count[%0d]: %0d samples %0d errs, required %0d/0", d, act_v[d].size(), fe_cnt[d], exp_v[d].size());
      end else for (int i = 0; i < exp_v[d].size(); i++) begin
        n_chk++;
        if (act_v[d][i] !== exp_v[d][i] || act_c[d][i] - rise_cyc[exp_p[d][i]] !== 4) begin
          n_fail++;
          $display("FAIL s32_sample[%0d][%0d]: %h after %0d clk, required %h after 4", d, i, act_v[d][i], act_c[d][i] - rise_cyc[exp_p[d][i]], exp_v[d][i]);
        end
      end
    end
    n_chk++;
    if (act_v[0].size() == 0 || act_v[0][0] !== 'hCAFE) begin
      n_fail++;
      $display("FAIL s32_cafe: first left sample missing or wrong, required cafe");
    end
  endtask

  task automatic test_truncated();
    do_reset(); clear_mon(); new_stream();
    add_slot(8, 'hA5); add_slot(16, $urandom);
    add_slot(16, 'h00FF); add_slot(16, $urandom);
    build(); play(0, p_lr.size()); model(1);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== exp_v[d].size() || fe_cnt[d] !== 1) begin
        n_fail++;
        $display("FAIL trunc_count[%0d]: %0d samples %0d err cycles, required %0d/1", d, act_v[d].size(), fe_cnt[d], exp_v[d].size());
      end else for (int i = 0; i < exp_v[d].size(); i++) begin
        n_chk++;
        if (act_v[d][i] !== exp_v[d][i] || act_c[d][i] - rise_cyc[exp_p[d][i]] !== 4) begin
          n_fail++;
          $display("FAIL trunc_sample[%0d][%0d]: %h after %0d clk, required %h after 4", d, i, act_v[d][i], act_c[d][i] - rise_cyc[exp_p[d][i]], exp_v[d][i]);
        end
      end
    end
    n_chk++;
    if (act_v[0].size() != 1 || act_v[0][0] !== 'h00FF) begin
      n_fail++;
      $display("FAIL trunc_left: %0d left samples, required exactly one 00ff", act_v[0].size());
    end
  endtask

  task automatic test_reset_mid();
    new_stream();
    add_slot(16, 'h5555); add_slot(16, 'h1111);
    add_slot(16, 'h0F0F); add_slot(16, 'h2222);
    add_slot(16, 'h0F0F); add_slot(16, 'h3333);
    build();
    play(0, 12);  // preamble plus part of the first left slot
    do_reset(); clear_mon();
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (so[d] !== '0 || sv[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_clear[%0d]: out=%h valid=%b, required 0/0", d, so[d], sv[d]);
      end
    end
    play(12, p_lr.size()); model(2);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== exp_v[d].size() || fe_cnt[d] !== 0) begin
        n_fail++;
        $display("FAIL midrst_count[%0d]: %0d samples %0d errs, required %0d/0", d, act_v[d].size(), fe_cnt[d], exp_v[d].size());
      end else for (int i = 0; i < exp_v[d].size(); i++) begin
        n_chk++;
        if (act_v[d][i] !== exp_v[d][i] || act_c[d][i] - rise_cyc[exp_p[d][i]] !== 4) begin
          n_fail++;
          $display("FAIL midrst_sample[%0d][%0d]: %h after %0d clk, required %h after 4", d, i, act_v[d][i], act_c[d][i] - rise_cyc[exp_p[d][i]], exp_v[d][i]);
        end
      end
    end
    n_chk++;
    if (act_v[0].size() == 0 || act_v[0][0] !== 'h0F0F) begin
      n_fail++;
      $display("FAIL midrst_first: first left sample after reset wrong, required 0f0f");
    end
  endtask

  task automatic test_random();
    do_reset(); clear_mon(); new_stream();
    for (int f = 0; f < 16; f++) begin
      int wl = pick_w();
      int wr = pick_w();
      add_slot(wl, {$urandom, $urandom});
      add_slot(wr, {$urandom, $urandom});
    end
    build(); play(0, p_lr.size()); model(1);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (act_v[d].size() !== exp_v[d].size() || fe_cnt[d] !== exp_err) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: %0d samples %0d errs, required %0d/%0d", d, act_v[d].size(), fe_cnt[d], exp_v[d].size(), exp_err);
      end else for (int i = 0; i < exp_v[d].size(); i++) begin
        n_chk++;
        if (act_v[d][i] !== exp_v[d][i] || act_c[d][i] - rise_cyc[exp_p[d][i]] !== 4) begin
          n_fail++;
          $display("FAIL rand_sample[%0d][%0d]: %h after %0d clk, required %h after 4", d, i, act_v[d][i], act_c[d][i] - rise_cyc[exp_p[d][i]], exp_v[d][i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_channels();
    test_slot32();
    test_truncated();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
